// File: rtl/muldiv_pkg.sv
// Shared decode constants, FSM state type and iteration count for the
// EXE-stage multiply/divide unit.
package muldiv_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    localparam int unsigned ITER_CNT = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the 64-bit accumulator: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module muldiv_core #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     operand,
    output logic [2*DATA_W-1:0]   acc_next
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    always_comb begin
        sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, operand};
        diff = acc[2*DATA_W-1:DATA_W-1] - {1'b0, operand};
        acc_next = acc;
        if (!is_div) begin
            if (acc[0])
                acc_next = {sum, acc[DATA_W-1:1]};
            else
                acc_next = {1'b0, acc[2*DATA_W-1:1]};
        end else begin
            if (!diff[DATA_W])
                acc_next = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            else
                acc_next = {acc[2*DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/exe_muldiv_unit.sv
// EXE-stage iterative multiply/divide unit owning the HI/LO registers.
// Stalls the pipeline for the duration of MULT/MULTU/DIV/DIVU.
module exe_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned      DATA_W    = 32,
    parameter logic [31:0]      DIV0_QUOT = 32'hFFFFFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                exe_valid,
    input  logic [31:0]         exe_instr_in,
    input  logic [DATA_W-1:0]   exe_rs_in,
    input  logic [DATA_W-1:0]   exe_rt_in,
    input  logic                flush,
    output logic                stall_req,
    output logic [DATA_W-1:0]   exe_hi,
    output logic [DATA_W-1:0]   exe_lo,
    output logic [DATA_W-1:0]   exe_mf_result,
    output logic                hilo_done
);

    localparam int unsigned CNT_W = $clog2(ITER_CNT);

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [2*DATA_W-1:0]    acc;
    logic [2*DATA_W-1:0]    acc_next;
    logic [DATA_W-1:0]      operand;
    logic                   sign_a;
    logic                   sign_b;
    logic                   is_div;
    logic                   div_zero;
    logic [DATA_W-1:0]      hi;
    logic [DATA_W-1:0]      lo;
    logic                   done;

    logic                   special;
    logic [5:0]             funct;
    logic                   is_muldiv;
    logic                   op_signed;
    logic                   op_div;
    logic                   is_mfhi;
    logic                   is_mflo;
    logic                   is_mthi;
    logic                   is_mtlo;
    logic                   start;
    logic [DATA_W-1:0]      rs_abs;
    logic [DATA_W-1:0]      rt_abs;
    logic [2*DATA_W-1:0]    prod_fix;
    logic [DATA_W-1:0]      fix_hi;
    logic [DATA_W-1:0]      fix_lo;
    logic                   unused_instr_bits;

    assign unused_instr_bits = ^exe_instr_in[25:6];

    always_comb begin
        special   = (exe_instr_in[31:26] == OP_SPECIAL);
        funct     = exe_instr_in[5:0];
        is_muldiv = special && (funct == FUNCT_MULT || funct == FUNCT_MULTU ||
                                funct == FUNCT_DIV  || funct == FUNCT_DIVU);
        op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
        op_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
        is_mfhi   = special && (funct == FUNCT_MFHI);
        is_mflo   = special && (funct == FUNCT_MFLO);
        is_mthi   = special && (funct == FUNCT_MTHI);
        is_mtlo   = special && (funct == FUNCT_MTLO);
        start     = exe_valid && is_muldiv && (state == IDLE) && !flush;
        rs_abs    = (op_signed && exe_rs_in[DATA_W-1]) ? -exe_rs_in : exe_rs_in;
        rt_abs    = (op_signed && exe_rt_in[DATA_W-1]) ? -exe_rt_in : exe_rt_in;
    end

    muldiv_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // Divide-by-zero leaves |rs| in the remainder, so the dividend sign fix
    // restores the original rs in HI; only LO needs overriding.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        if (is_div) begin
            fix_hi = sign_a ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
            if (div_zero)
                fix_lo = DIV0_QUOT;
            else
                fix_lo = (sign_a ^ sign_b) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        end else begin
            fix_hi = prod_fix[2*DATA_W-1:DATA_W];
            fix_lo = prod_fix[DATA_W-1:0];
        end
    end

    always_comb begin
        case (state)
            IDLE:      stall_req = start;
            CALC, FIX: stall_req = !flush;
            default:   stall_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            operand  <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign_a   <= op_signed && exe_rs_in[DATA_W-1];
                        sign_b   <= op_signed && exe_rt_in[DATA_W-1];
                        is_div   <= op_div;
                        div_zero <= (exe_rt_in == '0);
                        acc      <= op_div ? {{DATA_W{1'b0}}, rs_abs} : {{DATA_W{1'b0}}, rt_abs};
                        operand  <= op_div ? rt_abs : rs_abs;
                        count    <= '0;
                        state    <= CALC;
                    end else if (exe_valid && is_mthi) begin
                        hi <= exe_rs_in;
                    end else if (exe_valid && is_mtlo) begin
                        lo <= exe_rs_in;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (count == CNT_W'(ITER_CNT - 1)) begin
                        count <= '0;
                        state <= FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        exe_mf_result = '0;
        if (is_mfhi)
            exe_mf_result = hi;
        else if (is_mflo)
            exe_mf_result = lo;
    end

    assign exe_hi    = hi;
    assign exe_lo    = lo;
    assign hilo_done = done;

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
Iterative multiply/divide unit in the EXE stage, beside the ALU. It consumes the EXE-stage instruction and operands registered by the ID/EXE pipeline register, and owns the architectural HI/LO registers. It raises a stall request to the pipeline controller while a MULT/MULTU/DIV/DIVU is in flight, and returns HI/LO for MFHI/MFLO into the EXE result path.

Parameters:
DATA_W, 32, operand/HI/LO width; only 32 is supported.
DIV0_QUOT, 32'hFFFFFFFF, LO value written on divide-by-zero.

Ports:
clk  in  1  clock
reset  in  1  async active-low reset
exe_valid  in  1  EXE holds a real instruction (not a bubble)
exe_instr_in  in  32  EXE instruction word
exe_rs_in  in  32  rs operand (ALU opr1 path, after forwarding)
exe_rt_in  in  32  rt operand
flush  in  1  sync abandon of the current EXE instruction
stall_req  out  1  to PipelineController; hold IF/ID/EXE, bubble MEM
exe_hi  out  32  HI register
exe_lo  out  32  LO register
exe_mf_result  out  32  MFHI→HI, MFLO→LO, else 0
hilo_done  out  1  1-cycle pulse when a mult/div result is committed

Behaviour:
- Reset is asynchronous and active-low on reset; clock is clk. On reset: state=IDLE, HI=LO=0, stall_req=0, hilo_done=0, counter=0. Reset mid-operation discards the operation.
- Decode, combinational: op==6'b000000 and funct = 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO. start = exe_valid & is_muldiv & state==IDLE & ~flush.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - stall_req = start (combinational).
  - On start: latch |rs| and |rt| for signed ops (raw values for unsigned), latch the sign bits and the op, counter=0, go to CALC.
  - MTHI/MTLO with exe_valid & ~flush & ~stall_req: write HI/LO from exe_rs_in at the clock edge.
- CALC:
  - stall_req=1. One iteration per cycle, 32 cycles (counter 0..31), then go to FIX.
  - Mult: shift-add into a 64-bit product.
  - Div: restoring shift-subtract yielding quotient and remainder.
- FIX:
  - stall_req=1. Apply sign correction.
  - Mult: negate the 64-bit product if the signs differ.
  - Div: negate the quotient if the signs differ; negate the remainder if the dividend is negative.
  - Write HI = product[63:32] or remainder, LO = product[31:0] or quotient. Go to DONE.
- DONE: stall_req=0, hilo_done=1. The pipeline advances the instruction at this edge; go to IDLE. No restart from DONE, so the same held instruction is never re-executed.
- Latency: the instruction occupies EXE for 35 cycles (IDLE + 32 CALC + FIX + DONE); stall_req is high for 34. New HI/LO are visible from the DONE cycle onward, so a following MFHI reads the new value with no extra interlock.
- Divide-by-zero (rt==0): the full latency is still taken. LO=DIV0_QUOT, HI=rs as originally supplied (unsigned result semantics, no sign fix).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000 (wrap), HI=0. No trap.
- flush: from any state, go to IDLE at the next edge. HI/LO are unchanged, stall_req drops combinationally, hilo_done=0. flush has priority over start and MTHI/MTLO.
- exe_mf_result is combinational from the HI/LO registers. MFHI/MFLO never stall, because a preceding mult/div has already committed by construction.
- exe_valid=0 is ignored in IDLE. While not in IDLE the operand inputs are don't-care; latched copies are used.

Decomposition:
- Shared package `muldiv_pkg`: funct code constants (FUNCT_MULT..FUNCT_MTLO), state encoding (IDLE/CALC/FIX/DONE), ITER_CNT=32.
- One sub-module, `muldiv_core`: the 64-bit iteration datapath (shift-add / shift-subtract step, selected by an is_div input). The FSM, sign handling and HI/LO registers stay in the top module.

Test Plan:
- Reset with the FSM in mid-CALC → immediately HI=LO=0, stall_req=0, state IDLE; no hilo_done pulse.
- MULT rs=0xFFFFFFFE (-2), rt=3 → stall_req high 34 cycles; at DONE HI=0xFFFFFFFF, LO=0xFFFFFFFA, hilo_done for 1 cycle. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7/2 → LO=3, HI=1.
- DIVU rs=0x12345678, rt=0 → LO=0xFFFFFFFF, HI=0x12345678 after the full 35-cycle occupancy. DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- MTHI rs=0xA5A5A5A5, next cycle MFHI → exe_mf_result=0xA5A5A5A5 with no stall. MULT immediately followed by MFLO → MFLO returns the new LO.
- flush asserted on CALC cycle 10 of a MULT → stall_req low the same cycle, FSM IDLE next cycle, HI/LO keep their prior values, no hilo_done.
